// File: rtl/cfg_uart_slv_pkg.sv
// rtl/cfg_uart_slv_pkg.sv - shared enums and frame constants for the config serial endpoint
package cfg_uart_pkg;

  localparam int CMD_BYTES   = 3;
  localparam int RSP_BYTES   = 2;
  localparam int RX_TMO_BITS = 40;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HI,
    TX_LO
  } tx_state_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_e;

endpackage

// File: rtl/cfg_uart_slv_if.sv
// rtl/cfg_uart_slv_if.sv - core-side command/response bundle of the config serial endpoint
interface cfg_uart_slv_if;
  import cfg_uart_pkg::*;

  logic [8*CMD_BYTES-1:0] cfg_data;
  logic                   cmd_rdy;
  logic                   frm_err;
  logic [8*RSP_BYTES-1:0] resp_data;
  logic                   snd_resp;
  logic                   tx_busy;

  // Control unit side
  modport master (
    input  cfg_data, cmd_rdy, frm_err, tx_busy,
    output resp_data, snd_resp
  );

  // Serial endpoint side
  modport slave (
    output cfg_data, cmd_rdy, frm_err, tx_busy,
    input  resp_data, snd_resp
  );

endinterface

// File: rtl/cfg_uart_slv_tx8.sv
// rtl/cfg_uart_slv_tx8.sv - single-byte 8N1 serializer with start/done handshake
module cfg_uart_tx8
  import cfg_uart_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

  bit_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == BIT_LAST);
  assign tx_o    = tx_q;

  // Bit-timing state register; line idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= B_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // Next state; done fires in the last stop-bit cycle so a chained start leaves no gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done_o  = 1'b0;
    case (state_q)
      B_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = B_START;
          sh_d    = data_i;
          tx_d    = 1'b0;
        end
      end
      B_START: begin
        if (bit_end) begin
          state_d = B_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end
      end
      B_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = B_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
      B_STOP: begin
        if (bit_end) begin
          done_o = 1'b1;
          cnt_d  = '0;
          if (start_i) begin
            state_d = B_START;
            sh_d    = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = B_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = B_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cfg_uart_slv.sv
// rtl/cfg_uart_slv.sv - config serial endpoint: 3-byte command RX, 2-byte response TX (option CFG_RX_TIMEOUT_EN)
module cfg_uart_slv
  import cfg_uart_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RX_C,
  output logic          TX_C,
  cfg_uart_slv_if.slave bus
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [1:0]    LAST_B    = 2'(CMD_BYTES - 1);

  // ---------------- RX ----------------
  logic                            rx_s1_q, rx_s2_q, rx_prev_q;
  logic                            rx_fall;
  rx_state_e                       rx_state_q, rx_state_d;
  logic [CW-1:0]                   rx_cnt_q, rx_cnt_d;
  logic [2:0]                      rx_bit_q, rx_bit_d;
  logic [7:0]                      rx_sh_q, rx_sh_d;
  logic [1:0]                      byte_cnt_q, byte_cnt_d;
  logic [CMD_BYTES-1:0][7:0]       slot_q, slot_d;
  logic [8*CMD_BYTES-1:0]          cfg_data_q, cfg_data_d;
  logic                            cmd_rdy_q, cmd_rdy_d;
  logic                            frm_err_q, frm_err_d;
  logic                            tmo_hit;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // Double-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX_C;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

`ifdef CFG_RX_TIMEOUT_EN
  localparam int            TMO_CYC = RX_TMO_BITS * BAUD_DIV;
  localparam int            TW      = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Idle timer for a partially received frame; held at zero whenever a byte is in flight
  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (rx_state_q == RX_IDLE && byte_cnt_q != 2'd0 && !rx_fall) begin
      if (tmo_q == TMO_LAST) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // RX state and frame assembly registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      byte_cnt_q <= '0;
      slot_q     <= '0;
      cfg_data_q <= '0;
      cmd_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      byte_cnt_q <= byte_cnt_d;
      slot_q     <= slot_d;
      cfg_data_q <= cfg_data_d;
      cmd_rdy_q  <= cmd_rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // RX next state: mid-bit sampling, counter reloads on every transition
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_cnt_d = byte_cnt_q;
    slot_d     = slot_q;
    cfg_data_d = cfg_data_q;
    cmd_rdy_d  = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = RX_START;
        end else if (tmo_hit) begin
          byte_cnt_d = '0;
          frm_err_d  = 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // A high sample here is a glitch, not a start bit
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            if (byte_cnt_q == LAST_B) begin
              cfg_data_d = {slot_q[CMD_BYTES-1:1], rx_sh_q};
              cmd_rdy_d  = 1'b1;
              byte_cnt_d = '0;
            end else begin
              slot_d[LAST_B - byte_cnt_q] = rx_sh_q;
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else begin
            frm_err_d  = 1'b1;
            byte_cnt_d = '0;
          end
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  assign bus.cfg_data = cfg_data_q;
  assign bus.cmd_rdy  = cmd_rdy_q;
  assign bus.frm_err  = frm_err_q;

  // ---------------- TX ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] resp_lo_q, resp_lo_d;
  logic       tx_busy_q, tx_busy_d;
  logic       tx8_start;
  logic [7:0] tx8_byte;
  logic       tx8_done;

  // TX sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      resp_lo_q  <= '0;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      resp_lo_q  <= resp_lo_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // TX sequencer: high byte straight from the request, low byte chained on done
  always_comb begin
    tx_state_d = tx_state_q;
    resp_lo_d  = resp_lo_q;
    tx_busy_d  = tx_busy_q;
    tx8_start  = 1'b0;
    tx8_byte   = resp_lo_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx8_byte = bus.resp_data[15:8];
        if (bus.snd_resp) begin
          tx8_start  = 1'b1;
          resp_lo_d  = bus.resp_data[7:0];
          tx_busy_d  = 1'b1;
          tx_state_d = TX_HI;
        end
      end
      TX_HI: begin
        if (tx8_done) begin
          tx8_start  = 1'b1;
          tx_state_d = TX_LO;
        end
      end
      TX_LO: begin
        if (tx8_done) begin
          tx_busy_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_busy_d  = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  cfg_uart_tx8 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx8 (
    .clk    (clk),
    .rst    (rst),
    .start_i(tx8_start),
    .data_i (tx8_byte),
    .tx_o   (TX_C),
    .done_o (tx8_done)
  );

  assign bus.tx_busy = tx_busy_q;

endmodule

// File: tb/tb_cfg_uart_slv.sv
// tb/tb_cfg_uart_slv.sv - directed scoreboard bench for cfg_uart_slv
`timescale 1ns/1ps
module tb_cfg_uart_slv;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx_c;
  logic tx_c;

  cfg_uart_slv_if u_if();

  cfg_uart_slv #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .RX_C(rx_c),
    .TX_C(tx_c),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_cmd[$];
  logic [8:0]  exp_tx[$];
  logic [23:0] obs_cmd[$];
  logic [8:0]  obs_tx[$];
  int obs_cmd_n = 0;
  int obs_tx_n  = 0;
  int frm_n     = 0;
  int busy_n    = 0;
  int cmd_rd    = 0;
  int tx_rd     = 0;

  // Output monitor
  always @(negedge clk) begin
    if (u_if.cmd_rdy === 1'b1) begin
      obs_cmd.push_back(u_if.cfg_data);
      obs_cmd_n++;
    end
    if (u_if.frm_err === 1'b1) frm_n++;
    if (u_if.tx_busy === 1'b1) busy_n++;
  end

  // TX line decoder, samples mid-bit
  logic       dec_act = 1'b0;
  int         dec_cnt = 0;
  int         dec_k   = 0;
  logic [7:0] dec_b   = '0;
  always @(negedge clk) begin
    if (rst) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (tx_c === 1'b0) begin
        dec_act = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % BD == BD / 2) begin
        dec_k = dec_cnt / BD;
        if (dec_k >= 1 && dec_k <= 8) begin
          dec_b[dec_k-1] = tx_c;
        end else if (dec_k == 9) begin
          obs_tx.push_back({tx_c, dec_b});
          obs_tx_n++;
          dec_act = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stp);
    rx_c = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_c = b[i];
      repeat (BD) @(negedge clk);
    end
    rx_c = stp;
    repeat (BD) @(negedge clk);
    rx_c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_cmd.push_back({b0, b1, b2});
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
  endtask

  task automatic send_resp(input logic [15:0] d);
    u_if.resp_data = d;
    u_if.snd_resp  = 1'b1;
    @(negedge clk);
    u_if.snd_resp  = 1'b0;
  endtask

  task automatic expect_cmd(input string tag);
    logic [23:0] e;
    e = exp_cmd.pop_front();
    for (int i = 0; i < 400 && obs_cmd_n <= cmd_rd; i++) @(negedge clk);
    if (obs_cmd_n > cmd_rd) begin
      chk(tag, {8'h0, obs_cmd[cmd_rd]}, {8'h0, e});
      cmd_rd++;
    end else begin
      chk({tag, "_timeout"}, obs_cmd_n, cmd_rd + 1);
    end
  endtask

  task automatic expect_tx(input string tag);
    logic [8:0] e;
    e = exp_tx.pop_front();
    for (int i = 0; i < 400 && obs_tx_n <= tx_rd; i++) @(negedge clk);
    if (obs_tx_n > tx_rd) begin
      chk(tag, {23'h0, obs_tx[tx_rd]}, {23'h0, e});
      tx_rd++;
    end else begin
      chk({tag, "_timeout"}, obs_tx_n, tx_rd + 1);
    end
  endtask

  task automatic wait_tx_idle(input string tag);
    int i;
    for (i = 0; i < 800 && u_if.tx_busy !== 1'b0; i++) @(negedge clk);
    if (i >= 800) chk({tag, "_idle_timeout"}, u_if.tx_busy, 0);
  endtask

  int f0, n0, b0, exp_f;

  initial begin
    rst            = 1'b1;
    rx_c           = 1'b1;
    u_if.snd_resp  = 1'b0;
    u_if.resp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_c",     tx_c,          1);
    chk("rst_cfg_data", u_if.cfg_data, 0);
    chk("rst_cmd_rdy",  u_if.cmd_rdy,  0);
    chk("rst_frm_err",  u_if.frm_err,  0);
    chk("rst_tx_busy",  u_if.tx_busy,  0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame
    f0 = frm_n;
    send_frame(8'h0C, 8'h00, 8'h24);
    expect_cmd("t1_cmd");
    repeat (20) @(negedge clk);
    chk("t1_frm_err", frm_n, f0);
    chk("t1_single_pulse", obs_cmd_n, cmd_rd);
    chk("t1_hold", u_if.cfg_data, 24'h0C0024);

    // Response transmit, second request mid-transfer ignored
    b0 = busy_n;
    exp_tx.push_back({1'b1, 8'h0A});
    exp_tx.push_back({1'b1, 8'h5A});
    send_resp(16'h0A5A);
    chk("t2_busy_rise", u_if.tx_busy, 1);
    chk("t2_start_bit", tx_c, 0);
    repeat (100) @(negedge clk);
    send_resp(16'hFFFF);
    wait_tx_idle("t2");
    chk("t2_busy_len", busy_n - b0, 320);
    expect_tx("t2_byte_hi");
    expect_tx("t2_byte_lo");
    repeat (200) @(negedge clk);
    chk("t2_no_extra", obs_tx_n, tx_rd);

    // Short low glitch is a false start
    f0 = frm_n;
    n0 = obs_cmd_n;
    rx_c = 1'b0;
    repeat (4) @(negedge clk);
    rx_c = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_glitch_frm", frm_n, f0);
    chk("t3_glitch_cmd", obs_cmd_n, n0);
    send_frame(8'h3F, 8'h12, 8'h34);
    expect_cmd("t3_cmd");

    // Bad stop bit on second byte
    f0 = frm_n;
    n0 = obs_cmd_n;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    repeat (20) @(negedge clk);
    chk("t4_frm_err", frm_n, f0 + 1);
    chk("t4_no_cmd", obs_cmd_n, n0);
    send_frame(8'h08, 8'h15, 8'hA5);
    expect_cmd("t4_cmd");
    chk("t4_frm_after", frm_n, f0 + 1);

    // Partial frame followed by a long idle
    f0 = frm_n;
    send_byte(8'h55, 1'b1);
    repeat (700) @(negedge clk);
`ifdef CFG_RX_TIMEOUT_EN
    exp_f = 1;
    exp_cmd.push_back(24'h010203);
`else
    exp_f = 0;
    exp_cmd.push_back(24'h550102);
`endif
    chk("t5_timeout_frm", frm_n - f0, exp_f);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    expect_cmd("t5_cmd");
    repeat (20) @(negedge clk);
    chk("t5_frm_after", frm_n - f0, exp_f);

    // Clear any leftover partial frame
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Full duplex
    b0 = busy_n;
    fork
      send_frame(8'h0C, 8'h00, 8'h24);
      begin
        exp_tx.push_back({1'b1, 8'h05});
        exp_tx.push_back({1'b1, 8'hA5});
        send_resp(16'h05A5);
      end
    join
    wait_tx_idle("t6");
    chk("t6_busy_len", busy_n - b0, 320);
    expect_cmd("t6_cmd");
    expect_tx("t6_byte_hi");
    expect_tx("t6_byte_lo");

    // Reset in the middle of a transmission
    send_resp(16'h1234);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_tx_c",    tx_c,          1);
    chk("t7_rst_tx_busy", u_if.tx_busy,  0);
    chk("t7_rst_cfg",     u_if.cfg_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    b0 = busy_n;
    exp_tx.push_back({1'b1, 8'hC3});
    exp_tx.push_back({1'b1, 8'h3C});
    send_resp(16'hC33C);
    wait_tx_idle("t7");
    chk("t7_busy_len", busy_n - b0, 320);
    expect_tx("t7_byte_hi");
    expect_tx("t7_byte_lo");
    repeat (50) @(negedge clk);
    chk("t7_no_extra", obs_tx_n, tx_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
